dot_product_sequencer: RTL and testbench
========================================

Name: dot_product_sequencer

Overview:
Sequential front/back stage wrapped around the combinational 32x32 signed tree multiplier. It registers operand pairs into the multiplier's A/B inputs and consumes the 64-bit product P. Products are accumulated over a programmed number of terms, and the dot-product result is delivered with a valid/ready handshake. Multiplier timing is closed inside one clock: operands are registered and the product is accumulated on the next edge.

Parameters:
LEN_W, 8, width of the term-count input; max vector length is 2^LEN_W-1

Ports:
clk  input  1  system clock; one clock domain, all flops rising-edge
rst  input  1  reset, synchronous, active-high
start  input  1  begin a new dot product; sampled only in IDLE
len  input  LEN_W  number of operand pairs, latched on start
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts an operand pair
in_a  input  32  signed operand A
in_b  input  32  signed operand B
mul_a  output  32  registered operand to multiplier A
mul_b  output  32  registered operand to multiplier B
mul_p  input  64  product from multiplier P (combinational from mul_a/mul_b)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_acc  output  64  signed accumulated result
out_ovf  output  1  sticky signed-overflow flag for this result
busy  output  1  state != IDLE

Behaviour:
- Reset, synchronous: state IDLE; acc, out_acc, mul_a, mul_b all zero; issue_cnt 0; p_vld 0; out_ovf 0; in_ready 0; out_valid 0; busy 0.
- Reset asserted mid-operation: the transaction is abandoned and the block is fully in reset state on the next edge. No partial result is emitted.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start: issue_cnt<=len, acc<=0, ovf<=0.
  - If len==0, go to DONE. Otherwise go to RUN.
- start outside IDLE is ignored.
- RUN:
  - in_ready = (state==RUN) && (issue_cnt!=0).
  - Handshake in_valid&&in_ready: mul_a<=in_a, mul_b<=in_b, p_vld<=1, issue_cnt decrements.
  - No handshake: p_vld<=0, and mul_a/mul_b hold their values (no toggling).
- Accumulate stage: if p_vld, acc<=acc+mul_p on the edge after operand capture.
- RUN -> DRAIN on the edge where the last pair is accepted, i.e. issue_cnt becomes 0. in_ready is therefore low the cycle after the last handshake.
- DRAIN: one cycle, during which the final product accumulates. Then go to DONE, with out_acc = final acc.
- DONE:
  - out_valid=1; out_acc and out_ovf held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE; out_valid=0 next cycle.
  - out_acc keeps its last value in IDLE.
- Latency: last pair accepted at edge t gives out_valid high after edge t+2.
- len==0: out_valid high one cycle after start, out_acc=0.
- Bubbles (in_valid low) in RUN are allowed; they only stretch RUN.
- Arithmetic: 64-bit two's-complement add.
  - Overflow is detected when both addends have the same sign and the sum's sign differs.
  - out_ovf is set on any such event and stays set until the next start.
- Back-to-back: start may be asserted in the same cycle the FSM is in IDLE after a DONE handshake. There is no extra idle cycle requirement beyond that.

Optional Feature:
DOT_PRODUCT_SAT_EN
- Defined: on overflow, acc clamps to 0x7FFF_FFFF_FFFF_FFFF for positive overflow or 0x8000_0000_0000_0000 for negative overflow, and out_ovf is set. Later adds continue from the clamped value.
- Undefined: acc wraps modulo 2^64, and out_ovf still flags the wrap.

Test Plan:
- Basic dot product:
  - Stimulus: len=3; pairs (2,3), (-4,5), (7,-1), no bubbles.
  - Response: out_acc=0xFFFF_FFFF_FFFF_FFEB (-21), out_ovf=0, out_valid two edges after the third handshake.
- Zero length:
  - Stimulus: len=0 with start.
  - Response: out_valid=1 on the next cycle, out_acc=0, in_ready never high.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE; pulse start and in_valid.
  - Response: out_acc/out_valid stable, in_ready=0, start ignored. After out_ready=1, busy=0 the next cycle.
- Bubbles:
  - Stimulus: len=4; pairs (1,1), (2,2), (3,3), (4,4), with in_valid low 2 cycles between each.
  - Response: out_acc=30, mul_a/mul_b held during bubbles.
- Overflow:
  - Stimulus: len=3; each pair (0x8000_0000, 0x8000_0000), giving 2^62 each.
  - Response without DOT_PRODUCT_SAT_EN: out_acc=0xC000_0000_0000_0000, out_ovf=1.
  - Response with DOT_PRODUCT_SAT_EN: out_acc=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Reset in RUN:
  - Stimulus: assert rst after 2 of 5 pairs are accepted.
  - Response: next cycle all outputs zero and IDLE. A new len=1 pair (6,7) then gives out_acc=42, out_ovf=0.

Source files
------------

// File: rtl/dot_product_sequencer.sv
// ---------------------------------------------------------------------------
// dot_product_sequencer
//
// Sequential wrapper around an external combinational 32x32 signed multiplier.
// Operand pairs are accepted with a valid/ready handshake and registered onto
// mul_a/mul_b. The product mul_p returns within the same cycle and is
// accumulated on the following edge. After the programmed number of terms,
// the 64-bit signed sum is offered on out_acc with a valid/ready handshake.
//
// Optional feature macro: DOT_PRODUCT_SAT_EN
//   defined   - a signed overflow clamps the accumulator to the most positive
//               or most negative 64-bit value, and out_ovf is set
//   undefined - the accumulator wraps modulo 2^64, and out_ovf flags the wrap
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, len          begin a dot product of len terms (sampled in IDLE)
//   in_valid, in_ready  operand handshake; in_a/in_b are the signed operands
//   mul_a, mul_b        registered operands driven to the multiplier
//   mul_p               64-bit product returned by the multiplier
//   out_valid/out_ready result handshake; out_acc is the signed sum
//   out_ovf             sticky signed-overflow flag for this result
//   busy                high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module dot_product_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_acc,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
    localparam logic [63:0]      ACC_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]      ACC_MIN = 64'h8000_0000_0000_0000;

    state_t           state_r;
    logic [LEN_W-1:0] issue_cnt_r;
    logic [63:0]      acc_r;
    logic             ovf_r;
    logic             p_vld_r;
    logic             in_ready_r;
    logic [31:0]      mul_a_r;
    logic [31:0]      mul_b_r;
    logic             out_valid_r;
    logic [63:0]      out_acc_r;
    logic             out_ovf_r;
    logic             busy_r;

    logic [63:0]      sum_s;
    logic             ovf_event_s;
    logic [63:0]      acc_next_s;

    // Two's-complement add overflows when both addends share a sign and the
    // sum's sign differs from it.
    function automatic logic add_overflow(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input logic [63:0] s);
        return (x[63] == y[63]) && (s[63] != x[63]);
    endfunction

    // Clamp value for an overflow; the addends' common sign picks the rail.
    function automatic logic [63:0] sat_value(input logic neg);
        return neg ? ACC_MIN : ACC_MAX;
    endfunction

    // Accumulator adder, overflow detection and optional saturation.
    always_comb begin
        sum_s       = acc_r + mul_p;
        ovf_event_s = add_overflow(acc_r, mul_p, sum_s);
`ifdef DOT_PRODUCT_SAT_EN
        if (ovf_event_s) begin
            acc_next_s = sat_value(acc_r[63]);
        end else begin
            acc_next_s = sum_s;
        end
`else
        acc_next_s = sum_s;
`endif
    end

    // Sequencer FSM, operand capture, accumulate stage and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            issue_cnt_r <= '0;
            acc_r       <= 64'd0;
            ovf_r       <= 1'b0;
            p_vld_r     <= 1'b0;
            in_ready_r  <= 1'b0;
            mul_a_r     <= 32'd0;
            mul_b_r     <= 32'd0;
            out_valid_r <= 1'b0;
            out_acc_r   <= 64'd0;
            out_ovf_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // Accumulate the product of the operands captured last edge.
            if (p_vld_r) begin
                acc_r <= acc_next_s;
                if (ovf_event_s) begin
                    ovf_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    p_vld_r <= 1'b0;
                    if (start) begin
                        issue_cnt_r <= len;
                        acc_r       <= 64'd0;
                        ovf_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        if (len == '0) begin
                            state_r <= DONE;
                        end else begin
                            state_r    <= RUN;
                            in_ready_r <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (in_valid && in_ready_r) begin
                        mul_a_r     <= in_a;
                        mul_b_r     <= in_b;
                        p_vld_r     <= 1'b1;
                        issue_cnt_r <= issue_cnt_r - CNT_ONE;
                        // Last pair: stop accepting and let its product drain.
                        if (issue_cnt_r == CNT_ONE) begin
                            in_ready_r <= 1'b0;
                            state_r    <= DRAIN;
                        end
                    end else begin
                        // Bubble: operands hold so the multiplier does not toggle.
                        p_vld_r <= 1'b0;
                    end
                end

                DRAIN: begin
                    // The final product lands in acc_r on this edge.
                    p_vld_r <= 1'b0;
                    state_r <= DONE;
                end

                DONE: begin
                    p_vld_r <= 1'b0;
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                        // Snapshot once; the result stays frozen under back-pressure.
                        if (!out_valid_r) begin
                            out_acc_r <= acc_r;
                            out_ovf_r <= ovf_r;
                        end
                    end
                end

                default: begin
                    state_r     <= IDLE;
                    p_vld_r     <= 1'b0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign out_valid = out_valid_r;
    assign out_acc   = out_acc_r;
    assign out_ovf   = out_ovf_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dot_product_sequencer
//
// Directed self-checking bench for dot_product_sequencer. The external
// multiplier is modelled here as a combinational signed 32x32->64 product.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_dot_product_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_acc;
    logic        out_ovf;
    logic        busy;

    int total;
    int bad;

    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;

    // Combinational signed multiplier seen by the DUT.
    assign ext_a = {{32{mul_a[31]}}, mul_a};
    assign ext_b = {{32{mul_b[31]}}, mul_b};
    assign mul_p = ext_a * ext_b;

    dot_product_sequencer #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (out_acc !== 64'd0) begin bad++; $display("FAIL reset_out_acc got=%h exp=%h", out_acc, 64'd0); end
        total++; if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=%b", {in_ready, out_valid, busy, out_ovf}, 4'b0000); end
        total++; if ({mul_a, mul_b} !== 64'd0) begin bad++; $display("FAIL reset_mul got=%h exp=%h", {mul_a, mul_b}, 64'd0); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_start(8'd3);
        total++; if ({busy, in_ready} !== 2'b11) begin bad++; $display("FAIL basic_run got=%b exp=%b", {busy, in_ready}, 2'b11); end
        push(32'd2, 32'd3);
        push(-32'sd4, 32'd5);
        push(32'd7, -32'sd1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_low got=%b exp=%b", in_ready, 1'b0); end
        total++; if (mul_a !== 32'd7) begin bad++; $display("FAIL basic_mul_a got=%h exp=%h", mul_a, 32'd7); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=%b", out_valid, 1'b0); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=%b", out_valid, 1'b1); end
        total++; if (out_acc !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL basic_acc got=%h exp=%h", out_acc, 64'hFFFF_FFFF_FFFF_FFEB); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=%b", out_ovf, 1'b0); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b exp=%b", {out_valid, busy}, 2'b00); end
        total++; if (out_acc !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL basic_acc_kept got=%h exp=%h", out_acc, 64'hFFFF_FFFF_FFFF_FFEB); end
    endtask

    task automatic test_zero_len();
        do_start(8'd0);
        total++; if ({busy, in_ready} !== 2'b10) begin bad++; $display("FAIL zero_state got=%b exp=%b", {busy, in_ready}, 2'b10); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b exp=%b", out_valid, 1'b1); end
        total++; if (out_acc !== 64'd0) begin bad++; $display("FAIL zero_acc got=%h exp=%h", out_acc, 64'd0); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL zero_ready got=%b exp=%b", in_ready, 1'b0); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_start(8'd1);
        push(32'd3, 32'd4);
        tick();
        tick();
        // Hold the result while poking start and in_valid.
        for (int i = 0; i < 5; i++) begin
            start    = 1'b1;
            len      = 8'd2;
            in_valid = 1'b1;
            in_a     = 32'd100 + 32'(i);
            in_b     = 32'd9;
            tick();
            total++; if ({out_valid, in_ready, busy} !== 3'b101) begin bad++; $display("FAIL bp_flags cyc=%0d got=%b exp=%b", i, {out_valid, in_ready, busy}, 3'b101); end
            total++; if (out_acc !== 64'd12) begin bad++; $display("FAIL bp_acc cyc=%0d got=%h exp=%h", i, out_acc, 64'd12); end
        end
        total++; if (mul_a !== 32'd3) begin bad++; $display("FAIL bp_mul_a got=%h exp=%h", mul_a, 32'd3); end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if ({busy, out_valid} !== 2'b00) begin bad++; $display("FAIL bp_release got=%b exp=%b", {busy, out_valid}, 2'b00); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_start_ignored got=%b exp=%b", busy, 1'b0); end
    endtask

    task automatic test_bubbles();
        do_start(8'd4);
        for (int i = 1; i <= 4; i++) begin
            push(32'(i), 32'(i));
            if (i < 4) begin
                in_a = 32'hDEAD_BEEF;
                in_b = 32'hCAFE_F00D;
                tick();
                tick();
                total++; if ({mul_a, mul_b} !== {32'(i), 32'(i)}) begin bad++; $display("FAIL bub_hold i=%0d got=%h exp=%h", i, {mul_a, mul_b}, {32'(i), 32'(i)}); end
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bub_ready i=%0d got=%b exp=%b", i, in_ready, 1'b1); end
            end
        end
        tick();
        tick();
        total++; if (out_acc !== 64'd30) begin bad++; $display("FAIL bub_acc got=%h exp=%h", out_acc, 64'd30); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [63:0] exp_acc;
`ifdef DOT_PRODUCT_SAT_EN
        exp_acc = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        exp_acc = 64'hC000_0000_0000_0000;
`endif
        do_start(8'd3);
        push(32'h8000_0000, 32'h8000_0000);
        push(32'h8000_0000, 32'h8000_0000);
        push(32'h8000_0000, 32'h8000_0000);
        tick();
        tick();
        total++; if (out_acc !== exp_acc) begin bad++; $display("FAIL ovf_acc got=%h exp=%h", out_acc, exp_acc); end
        total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", out_ovf, 1'b1); end
        // Handshake, leaving the FSM in IDLE for the back-to-back start.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_start(8'd2);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=%b", in_ready, 1'b1); end
        push(-32'sd3, 32'd5);
        push(-32'sd2, -32'sd2);
        tick();
        tick();
        total++; if (out_acc !== 64'hFFFF_FFFF_FFFF_FFF5) begin bad++; $display("FAIL b2b_acc got=%h exp=%h", out_acc, 64'hFFFF_FFFF_FFFF_FFF5); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf_clear got=%b exp=%b", out_ovf, 1'b0); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_in_run();
        do_start(8'd5);
        in_valid = 1'b1;
        push(32'd1, 32'd1);
        push(32'd2, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000) begin bad++; $display("FAIL rir_flags got=%b exp=%b", {in_ready, out_valid, busy, out_ovf}, 4'b0000); end
        total++; if (out_acc !== 64'd0) begin bad++; $display("FAIL rir_acc got=%h exp=%h", out_acc, 64'd0); end
        total++; if ({mul_a, mul_b} !== 64'd0) begin bad++; $display("FAIL rir_mul got=%h exp=%h", {mul_a, mul_b}, 64'd0); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rir_no_result got=%b exp=%b", out_valid, 1'b0); end
        do_start(8'd1);
        push(32'd6, 32'd7);
        tick();
        tick();
        total++; if (out_acc !== 64'd42) begin bad++; $display("FAIL rir_new_acc got=%h exp=%h", out_acc, 64'd42); end
        total++; if ({out_valid, out_ovf} !== 2'b10) begin bad++; $display("FAIL rir_new_flags got=%b exp=%b", {out_valid, out_ovf}, 2'b10); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_bubbles();
        test_overflow();
        test_back_to_back();
        test_reset_in_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
